// File: rtl/pipe_stage_if.sv
// Handshake bundle for one pipeline register: upstream side (in_*),
// downstream side (out_*) and the stage-local flush request.
interface pipe_stage_if #(
    parameter int DATA_W = 64
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    // Environment side: drives input payload, downstream ready and flush
    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    // Pipeline register side
    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register between two processor stages.
// SKID=0: one entry, in_ready is combinational from out_ready.
// SKID=1: main + skid entry, in_ready comes straight from a flop so the
// upstream ready path is cut while full throughput is kept.
// Flush empties the stage but never touches the data registers.
module pipe_stage_reg #(
    parameter int                DATA_W     = 64,
    parameter int                SKID       = 0,
    parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    pipe_stage_if.slave  bus
);

    generate
        if (SKID == 0) begin : g_single
            logic              valid_reg;
            logic [DATA_W-1:0] data_reg;
            logic              accept;

            // A slot opens up whenever the held entry leaves this cycle
            assign bus.in_ready  = !valid_reg || bus.out_ready;
            assign accept        = bus.in_valid && bus.in_ready;
            assign bus.out_valid = valid_reg;
            assign bus.out_data  = data_reg;

            // Single-entry register: load on accept, drain on take, flush wins
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg <= 1'b0;
                    data_reg  <= RESET_DATA;
                end else if (bus.flush) begin
                    valid_reg <= 1'b0;
                end else if (accept) begin
                    valid_reg <= 1'b1;
                    data_reg  <= bus.in_data;
                end else if (bus.out_ready) begin
                    valid_reg <= 1'b0;
                end
            end
        end else begin : g_skid
            typedef enum logic [1:0] {
                EMPTY = 2'd0,
                BUSY  = 2'd1,
                FULL  = 2'd2
            } state_t;

            state_t            state_reg;
            logic              in_ready_reg;
            logic              out_valid_reg;
            logic [DATA_W-1:0] main_data_reg;
            logic [DATA_W-1:0] skid_data_reg;
            logic              accept;
            logic              take;

            assign accept        = bus.in_valid && in_ready_reg;
            assign take          = out_valid_reg && bus.out_ready;
            assign bus.in_ready  = in_ready_reg;
            assign bus.out_valid = out_valid_reg;
            assign bus.out_data  = main_data_reg;

            // Occupancy FSM with registered ready/valid; output always comes from main
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg     <= EMPTY;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                    main_data_reg <= RESET_DATA;
                    skid_data_reg <= RESET_DATA;
                end else if (bus.flush) begin
                    state_reg     <= EMPTY;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end else begin
                    case (state_reg)
                        EMPTY: begin
                            if (accept) begin
                                main_data_reg <= bus.in_data;
                                out_valid_reg <= 1'b1;
                                state_reg     <= BUSY;
                            end
                        end
                        BUSY: begin
                            if (accept && take) begin
                                main_data_reg <= bus.in_data;
                            end else if (accept) begin
                                // Downstream stalled: park the new item behind main
                                skid_data_reg <= bus.in_data;
                                in_ready_reg  <= 1'b0;
                                state_reg     <= FULL;
                            end else if (take) begin
                                out_valid_reg <= 1'b0;
                                state_reg     <= EMPTY;
                            end
                        end
                        FULL: begin
                            if (take) begin
                                main_data_reg <= skid_data_reg;
                                in_ready_reg  <= 1'b1;
                                state_reg     <= BUSY;
                            end
                        end
                        default: begin
                            state_reg     <= EMPTY;
                            in_ready_reg  <= 1'b1;
                            out_valid_reg <= 1'b0;
                        end
                    endcase
                end
            end
        end
    endgenerate

endmodule
